// File: rtl/blink_pkg.sv
// Shared types and constants for the multi-channel LED blinker.
package blink_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        OFF     = 2'd0,
        ON      = 2'd1,
        BLINK   = 2'd2,
        ONESHOT = 2'd3
    } mode_e;

    // Channel-index width; a single channel still gets a 1-bit index.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_blink_if.sv
// Config bus from the board-control register block plus LED/status outputs.
// Handshake: cfg_we is a one-cycle strobe with no ready; every write is accepted on the edge it is seen.
interface multi_blink_if
    import blink_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int PBITS = 8
) ();
    localparam int CHW = ch_w(NCH);

    logic                          cfg_we;
    logic [CHW-1:0]                cfg_ch;
    mode_e                         cfg_mode;
    logic [PBITS-1:0]              cfg_period;
    logic                          tick;
    logic [NCH-1:0]                led;
    logic [NCH-1:0]                flg;
    logic [NCH-1:0][MODE_W-1:0]    mode_dbg;

    modport master (
        output cfg_we, cfg_ch, cfg_mode, cfg_period,
        input  tick, led, flg, mode_dbg
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_mode, cfg_period,
        output tick, led, flg, mode_dbg
    );
endinterface

// File: rtl/blink_chan.sv
// One LED channel: mode state machine, phase counter and registered led/flg.
module blink_chan
    import blink_pkg::*;
#(
    parameter int               PBITS   = 8,
    parameter logic [PBITS-1:0] RST_PER = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              we,
    input  mode_e             cfg_mode,
    input  logic [PBITS-1:0]  cfg_period,
    output logic              led,
    output logic              flg,
    output logic [MODE_W-1:0] mode_o
);
    mode_e            mode_q, mode_d;
    logic [PBITS-1:0] period_q, period_d;
    logic [PBITS-1:0] ph_cnt_q, ph_cnt_d;
    logic             led_q, led_d;
    logic             flg_q, flg_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= OFF;
            period_q <= RST_PER;
            ph_cnt_q <= '0;
            led_q    <= 1'b0;
            flg_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            ph_cnt_q <= ph_cnt_d;
            led_q    <= led_d;
            flg_q    <= flg_d;
        end
    end

    // A write takes priority, so a tick arriving on the same edge is dropped.
    always_comb begin
        mode_d   = mode_q;
        period_d = period_q;
        ph_cnt_d = ph_cnt_q;
        led_d    = led_q;
        flg_d    = 1'b0;
        if (we) begin
            mode_d   = cfg_mode;
            period_d = cfg_period;
            ph_cnt_d = '0;
            led_d    = (cfg_mode == ON) || (cfg_mode == ONESHOT);
        end else begin
            case (mode_q)
                OFF: begin
                    led_d    = 1'b0;
                    ph_cnt_d = '0;
                end
                ON: begin
                    led_d    = 1'b1;
                    ph_cnt_d = '0;
                end
                BLINK: begin
                    if (tick) begin
                        if (ph_cnt_q == period_q) begin
                            ph_cnt_d = '0;
                            led_d    = ~led_q;
                            flg_d    = 1'b1;
                        end else begin
                            ph_cnt_d = ph_cnt_q + PBITS'(1);
                        end
                    end
                end
                ONESHOT: begin
                    led_d = 1'b1;
                    if (tick) begin
                        if (ph_cnt_q == period_q) begin
                            led_d    = 1'b0;
                            flg_d    = 1'b1;
                            mode_d   = OFF;
                            ph_cnt_d = '0;
                        end else begin
                            ph_cnt_d = ph_cnt_q + PBITS'(1);
                        end
                    end
                end
                default: mode_d = OFF;
            endcase
        end
    end

    assign led    = led_q;
    assign flg    = flg_q;
    assign mode_o = mode_q;
endmodule

// File: rtl/multi_blink.sv
// Multi-channel LED blinker: shared prescaler tick, channel write decode, per-channel blink_chan.
module multi_blink
    import blink_pkg::*;
#(
    parameter int               NCH     = 4,
    parameter int               CBITS   = 13,
    parameter int               PBITS   = 8,
    parameter logic [PBITS-1:0] RST_PER = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    multi_blink_if.slave       bus
);
    localparam int CHW = ch_w(NCH);

    logic [CBITS-1:0]           pre_cnt_q, pre_cnt_d;
    logic                       tick_q, tick_d;
    logic                       ch_ok;
    logic [NCH-1:0]             led_w;
    logic [NCH-1:0]             flg_w;
    logic [NCH-1:0][MODE_W-1:0] mode_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            tick_q    <= tick_d;
        end
    end

    // Free-running: config writes never disturb the shared phase reference.
    always_comb begin
        pre_cnt_d = pre_cnt_q + CBITS'(1);
        tick_d    = &pre_cnt_q;
    end

    assign ch_ok = (32'(bus.cfg_ch) < 32'(NCH));

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        blink_chan #(
            .PBITS   (PBITS),
            .RST_PER (RST_PER)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick       (tick_q),
            .we         (bus.cfg_we && ch_ok && (bus.cfg_ch == CHW'(g))),
            .cfg_mode   (bus.cfg_mode),
            .cfg_period (bus.cfg_period),
            .led        (led_w[g]),
            .flg        (flg_w[g]),
            .mode_o     (mode_w[g])
        );
    end

    assign bus.tick     = tick_q;
    assign bus.led      = led_w;
    assign bus.flg      = flg_w;
    assign bus.mode_dbg = mode_w;
endmodule

// File: tb/tb_multi_blink.sv
// Randomized bench for multi_blink against a tick-counting reference model, plus an NCH=3 range-check instance.
module tb_multi_blink;
    import blink_pkg::*;

    localparam int NCH   = 4;
    localparam int CBITS = 3;
    localparam int PBITS = 8;
    localparam int TPER  = 1 << CBITS;
    localparam int EW    = 1 + NCH + NCH + 2 * NCH;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_blink_if #(.NCH(NCH), .PBITS(PBITS)) bus ();
    multi_blink_if #(.NCH(3),   .PBITS(PBITS)) bus3 ();

    multi_blink #(.NCH(NCH), .CBITS(CBITS), .PBITS(PBITS), .RST_PER(8'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    multi_blink #(.NCH(3), .CBITS(CBITS), .PBITS(PBITS), .RST_PER(8'd0)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each channel is described by ticks consumed since its last write:
    // BLINK led = (n / (period+1)) odd, ONESHOT lit while n <= period.
    mode_e             m_mode [NCH];
    int                m_per  [NCH];
    int                m_n    [NCH];
    int                cyc;
    logic              tick_in;
    logic [NCH-1:0]    lv, fv;
    logic [2*NCH-1:0]  mv;
    logic [EW-1:0]     exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0;
            exp_q.delete();
            for (int i = 0; i < NCH; i++) begin
                m_mode[i] = OFF;
                m_per[i]  = 0;
                m_n[i]    = 0;
            end
        end else begin
            tick_in = (cyc > 0) && (cyc % TPER == 0);
            cyc++;
            for (int i = 0; i < NCH; i++) begin
                fv[i] = 1'b0;
                if (bus.cfg_we && bus.cfg_ch == 2'(i)) begin
                    m_mode[i] = bus.cfg_mode;
                    m_per[i]  = int'(bus.cfg_period);
                    m_n[i]    = 0;
                end else if (tick_in && (m_mode[i] == BLINK || m_mode[i] == ONESHOT)) begin
                    m_n[i]++;
                    if (m_mode[i] == BLINK) begin
                        fv[i] = (m_n[i] % (m_per[i] + 1) == 0);
                    end else if (m_n[i] == m_per[i] + 1) begin
                        fv[i]     = 1'b1;
                        m_mode[i] = OFF;
                    end
                end
                case (m_mode[i])
                    ON:      lv[i] = 1'b1;
                    BLINK:   lv[i] = ((m_n[i] / (m_per[i] + 1)) % 2) == 1;
                    ONESHOT: lv[i] = 1'b1;
                    default: lv[i] = 1'b0;
                endcase
                mv[2*i +: 2] = m_mode[i];
            end
            exp_q.push_back({(cyc % TPER == 0), lv, fv, mv});
        end
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0]  e;
    logic [NCH-1:0] flg_prev = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_tick", 32'(bus.tick), 32'd0);
            check("rst_led",  32'(bus.led),  32'd0);
            check("rst_flg",  32'(bus.flg),  32'd0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tick", 32'(bus.tick),     32'(e[EW-1]));
            check("led",  32'(bus.led),      32'(e[EW-2 -: NCH]));
            check("flg",  32'(bus.flg),      32'(e[2*NCH +: NCH]));
            check("mode", 32'(bus.mode_dbg), 32'(e[2*NCH-1:0]));
        end
        check("flg_pulse", 32'(flg_prev & bus.flg), 32'd0);
        flg_prev = bus.flg;
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int ch, input mode_e m, input int p);
        bus.cfg_we     = 1'b1;
        bus.cfg_ch     = 2'(ch);
        bus.cfg_mode   = m;
        bus.cfg_period = 8'(p);
        @(negedge clk);
        bus.cfg_we     = 1'b0;
    endtask

    task automatic wr3(input int ch, input mode_e m, input int p);
        bus3.cfg_we     = 1'b1;
        bus3.cfg_ch     = 2'(ch);
        bus3.cfg_mode   = m;
        bus3.cfg_period = 8'(p);
        @(negedge clk);
        bus3.cfg_we     = 1'b0;
    endtask

    task automatic wait_tick(input int budget);
        int cnt = 0;
        while (!bus.tick && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        if (!bus.tick) check("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_toggle(input int ch, input int p);
        logic l0;
        int   cnt = 0;
        l0 = bus.led[ch];
        while (bus.led[ch] == l0 && cnt < 4 * (p + 1) * TPER) begin
            @(negedge clk);
            cnt++;
        end
        check("live_budget", 32'(cnt <= (p + 1) * TPER + 1), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.cfg_we      = 1'b0;
        bus.cfg_ch      = '0;
        bus.cfg_mode    = OFF;
        bus.cfg_period  = '0;
        bus3.cfg_we     = 1'b0;
        bus3.cfg_ch     = '0;
        bus3.cfg_mode   = OFF;
        bus3.cfg_period = '0;

        idle(3);
        rst_n = 1'b1;
        idle(30);

        wr(0, BLINK, 0);
        idle(40);
        wr(1, BLINK, 2);
        wait_toggle(1, 2);
        wr(2, ON, 0);
        wr(3, ONESHOT, 1);
        idle(40);
        check("ch3_selfclear", 32'(bus.mode_dbg[3]), 32'(OFF));

        // Write ch1 exactly on the edge that consumes a tick.
        wait_tick(2 * TPER);
        wr(1, BLINK, 2);
        idle(30);

        // Out-of-range channel index on the 3-channel instance.
        wr3(0, ON, 0);
        check("r3_led_a", 32'(bus3.led), 32'b001);
        wr3(3, BLINK, 5);
        check("r3_led_b",  32'(bus3.led),      32'b001);
        check("r3_mode_b", 32'(bus3.mode_dbg), 32'b00_00_01);
        wr3(2, ON, 0);
        check("r3_led_c", 32'(bus3.led), 32'b101);

        // Asynchronous reset while ticking and blinking.
        wr(0, BLINK, 0);
        idle(5);
        wait_tick(2 * TPER);
        check("pre_rst_tick", 32'(bus.tick), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_tick", 32'(bus.tick), 32'd0);
        check("async_led",  32'(bus.led),  32'd0);
        check("async_flg",  32'(bus.flg),  32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(30);

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) wait_tick(2 * TPER);
            wr($urandom_range(0, NCH - 1), mode_e'($urandom_range(0, 3)), $urandom_range(0, 3));
            idle($urandom_range(0, 20));
        end

        wr(0, BLINK, 1);
        wait_toggle(0, 1);
        idle(50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
